rr_priority_arbiter: RTL and testbench
======================================

Name: rr_priority_arbiter

Overview:
- Shares one downstream resource between N_REQ requesters. Uses highest-index-first priority encoding, either fixed or round-robin.
- Issues a registered one-hot grant plus its encoded index.
- Holds the grant while the owner keeps requesting. Forcibly rotates ownership after MAX_HOLD cycles if another requester is waiting.
- Sits in front of the priority encoder datapath, turning its combinational pick into a sequenced ownership protocol.

Parameters:
- N_REQ, 4, number of requesters (power of two, >=2).
- IDX_W, $clog2(N_REQ) = 2, width of the grant index.
- MAX_HOLD, 8, max consecutive grant cycles before preemption when others are pending (>=1).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  request vector; bit i held high by requester i while it wants or uses the resource.
- mode  in  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
- gnt  out  N_REQ  one-hot grant, registered.
- gnt_valid  out  1  high when gnt is non-zero.
- gnt_pos  out  IDX_W  index of the granted requester; 0 when gnt_valid=0.
- preempt  out  1  one-cycle pulse in the cycle a grant is removed by MAX_HOLD expiry.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, gnt=0, gnt_valid=0, gnt_pos=0, preempt=0, hold_cnt=0, last=0.
  - Applies mid-grant too: outputs are 0 in the cycle after the reset edge.
  - No arbitration occurs during any cycle rst=1.
- States: IDLE and GRANT.
- IDLE:
  - If req==0, remain in IDLE.
  - Else pick a winner w, register gnt=1<<w, gnt_pos=w, gnt_valid=1, last=w, hold_cnt=0, and go to GRANT.
  - Latency: req sampled high at edge t gives grant visible after edge t (one cycle).
- Winner selection:
  - Fixed (mode=0): highest set index of req.
  - Round-robin (mode=1): search order last-1, last-2, … wrapping modulo N_REQ, ending at last; first set bit wins.
  - With last=0 after reset, the round-robin order is 3,2,1,0, identical to fixed.
  - last updates on every grant in both modes, so mode switches need no resync.
- GRANT (owner o):
  - req[o]=0: release. Next cycle gnt=0, gnt_valid=0, gnt_pos=0, state=IDLE.
  - req[o]=1 and hold_cnt==MAX_HOLD-1 and (req & ~(1<<o))!=0: preempt. Next cycle gnt=0, preempt=1, state=IDLE.
  - Otherwise stay in GRANT. hold_cnt increments, saturating at MAX_HOLD-1; it stays saturated while no one else requests.
  - Release has priority over preempt in the same cycle (preempt=0).
- Bus gaps:
  - Minimum one idle cycle between successive grants.
  - A requester still asserting req in the IDLE cycle is arbitrated normally. In fixed mode a preempted highest-index owner can win again; that is intended.
- preempt is high only in the first IDLE cycle after a preemption. It is 0 at all other times.
- Requests changing during GRANT for non-owners have no effect until IDLE.
- mode changes during GRANT take effect at the next IDLE evaluation.
- Invariants: gnt one-hot or zero; gnt_valid == |gnt; gnt_pos == encode(gnt); never grants a requester whose req was 0 at the sampling edge.
- hold_cnt width is $clog2(MAX_HOLD+1). No arithmetic wider than IDX_W+1 is needed for the wrap computation.

Decomposition:
- Package prio_arb_pkg: state enum (IDLE, GRANT), N_REQ and IDX_W defaults, and a function onehot_to_idx.
- One sub-module, rr_mask_encoder. It is purely combinational.
  - Inputs: req, last, mode.
  - Outputs: any, win_idx.
  - Implements the rotate-by-last, highest-index-first pick.
- The controller FSM, hold counter and output registers live in rr_priority_arbiter.

Test Plan:
- Reset then req=4'b1010, mode=0 -> one cycle later gnt=4'b1000, gnt_pos=3, gnt_valid=1; drop req[3] -> next cycle gnt=0; following cycle gnt=4'b0010, gnt_pos=1.
- mode=1, req=4'b1111 held with each owner dropping its req for exactly one cycle after being granted -> grant sequence pos 3,2,1,0,3 with one gap cycle between grants.
- mode=0, req=4'b1001 held, MAX_HOLD=8 -> gnt=4'b1000 for exactly 8 cycles, then gnt=0 with preempt=1, then gnt=4'b1000 again (fixed priority rewins); in mode=1 the regrant goes to pos 0.
- Single requester req=4'b0100 held for 20 cycles -> gnt=4'b0100 continuously, preempt never asserted.
- Assert rst while gnt=4'b0010 -> next cycle gnt=0, gnt_pos=0, gnt_valid=0, preempt=0; after rst drops with req=4'b0011, mode=1 -> gnt_pos=1 (last reset to 0).
- Owner drops req in the same cycle hold_cnt reaches MAX_HOLD-1 with others pending -> release path taken, preempt stays 0; random-traffic run checks the one-hot and zero-req-never-granted invariants every cycle.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// Shared types and defaults for the round-robin / fixed priority arbiter.
// Holds the controller state enum and a one-hot to index helper.
package prio_arb_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int IDX_W_DEF    = $clog2(N_REQ_DEF);
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index of the highest set bit; 0 for an all-zero vector.
    function automatic int onehot_to_idx(input logic [31:0] v);
        onehot_to_idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) onehot_to_idx = i;
        end
    endfunction

endpackage

// File: rtl/rr_mask_encoder.sv
// Combinational pick: highest-index-first search starting just below 'last'
// (round-robin) or just below index 0, i.e. from the top (fixed priority).
module rr_mask_encoder
    import prio_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    input  logic             mode,
    output logic             any,
    output logic [IDX_W-1:0] win_idx
);

    logic [IDX_W-1:0] base;

    // Fixed priority is round-robin with the pointer pinned at 0, so the
    // first candidate is N_REQ-1 via modulo wrap of the IDX_W-bit subtract.
    assign base = mode ? last : '0;

    always_comb begin
        logic [IDX_W-1:0] idx;
        idx     = '0;
        any     = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = base - IDX_W'(k);
            if (!any && req[idx]) begin
                any     = 1'b1;
                win_idx = idx;
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Ownership controller: registers a one-hot grant from the encoder's pick,
// holds it while the owner requests, and preempts after MAX_HOLD cycles.
module rr_priority_arbiter
    import prio_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int IDX_W    = $clog2(N_REQ),
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             mode,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_pos,
    output logic             preempt
);

    localparam int               HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    // Handshake: requester i raises req[i] and keeps it high while it wants or
    // uses the resource; gnt[i] high means it owns the resource this cycle;
    // dropping req[i] releases it, and ownership may also be withdrawn by a
    // preemption, after which the requester must rearbitrate from IDLE.
    arb_state_e       state, state_n;
    logic [N_REQ-1:0] gnt_n;
    logic             gnt_valid_n;
    logic [IDX_W-1:0] gnt_pos_n;
    logic             preempt_n;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic [IDX_W-1:0] last, last_n;

    logic             any;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] owner;
    logic             others_req;

    rr_mask_encoder #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_enc (
        .req     (req),
        .last    (last),
        .mode    (mode),
        .any     (any),
        .win_idx (win_idx)
    );

    assign owner      = IDX_W'(onehot_to_idx(32'(gnt)));
    assign others_req = |(req & ~gnt);

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        gnt_valid_n = gnt_valid;
        gnt_pos_n   = gnt_pos;
        preempt_n   = 1'b0;
        hold_cnt_n  = hold_cnt;
        last_n      = last;
        case (state)
            IDLE: begin
                if (any) begin
                    state_n          = GRANT;
                    gnt_n            = '0;
                    gnt_n[win_idx]   = 1'b1;
                    gnt_valid_n      = 1'b1;
                    gnt_pos_n        = win_idx;
                    last_n           = win_idx;
                    hold_cnt_n       = '0;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    state_n     = IDLE;
                    gnt_n       = '0;
                    gnt_valid_n = 1'b0;
                    gnt_pos_n   = '0;
                    hold_cnt_n  = '0;
                end else if (hold_cnt == HOLD_LAST && others_req) begin
                    state_n     = IDLE;
                    gnt_n       = '0;
                    gnt_valid_n = 1'b0;
                    gnt_pos_n   = '0;
                    hold_cnt_n  = '0;
                    preempt_n   = 1'b1;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_pos   <= '0;
            preempt   <= 1'b0;
            hold_cnt  <= '0;
            last      <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            gnt_valid <= gnt_valid_n;
            gnt_pos   <= gnt_pos_n;
            preempt   <= preempt_n;
            hold_cnt  <= hold_cnt_n;
            last      <= last_n;
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Randomized and directed bench for rr_priority_arbiter against an
// ownership-level reference model (owner id, cycles held, last winner).
module tb_rr_priority_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         mode;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_pos;
    logic         preempt;

    always #5 clk = ~clk;

    rr_priority_arbiter #(
        .N_REQ    (N),
        .IDX_W    (2),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_pos   (gnt_pos),
        .preempt   (preempt)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_owner   = -1;
    int          m_last    = 0;
    int          m_held    = 0;
    bit          m_preempt = 1'b0;
    logic [N-1:0] m_req_at_edge;
    bit          m_new_grant = 1'b0;

    function automatic int pick(input logic [N-1:0] r, input logic md, input int lst);
        int start;
        start = md ? (lst + N - 1) % N : N - 1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start - k + N) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        m_req_at_edge = req;
        m_new_grant   = 1'b0;
        m_preempt     = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_last  = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            int w;
            w = pick(req, mode, m_last);
            if (w >= 0) begin
                m_owner     = w;
                m_last      = w;
                m_held      = 1;
                m_new_grant = 1'b1;
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else if (m_held >= MAX_HOLD && (req & ~(N'(1) << m_owner)) != '0) begin
            m_owner   = -1;
            m_preempt = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick();
        logic [N-1:0] exp_gnt;
        model_step();
        @(posedge clk);
        #1;
        exp_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("gnt_pos", 32'(gnt_pos), (m_owner >= 0) ? m_owner : 0);
        check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("preempt", 32'(preempt), 32'(m_preempt));
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
        if (m_new_grant && gnt_valid)
            check("granted_req_high", 32'(m_req_at_edge[gnt_pos]), 32'd1);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        mode = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        bit was_valid;

        rst = 1'b1; req = '0; mode = 1'b0;
        do_reset();
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_valid", 32'(gnt_valid), 32'd0);

        // Fixed priority basic grant and release.
        mode = 1'b0; req = 4'b1010;
        tick();
        check("t1_gnt3", 32'(gnt), 32'h8);
        req = 4'b0010;
        tick();
        check("t1_release", 32'(gnt), 32'h0);
        tick();
        check("t1_gnt1", 32'(gnt), 32'h2);
        check("t1_pos1", 32'(gnt_pos), 32'd1);

        // Round-robin rotation, each owner drops its req for one cycle.
        do_reset();
        mode = 1'b1;
        exp_q = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        was_valid = 1'b0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            req = gnt_valid ? (4'b1111 & ~gnt) : 4'b1111;
            was_valid = gnt_valid;
            tick();
            if (gnt_valid && !was_valid) check("rr_seq", 32'(gnt_pos), 32'(exp_q.pop_front()));
        end
        check("rr_seq_done", exp_q.size(), 0);

        // MAX_HOLD preemption, fixed and round-robin.
        for (int md = 0; md < 2; md++) begin
            do_reset();
            mode = md[0]; req = 4'b1001;
            tick();
            cnt = (gnt == 4'b1000) ? 1 : 0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (gnt == 4'b1000) cnt++;
                else break;
            end
            check("hold_len", cnt, MAX_HOLD);
            check("preempt_pulse", 32'(preempt), 32'd1);
            tick();
            check("preempt_clear", 32'(preempt), 32'd0);
            check("regrant_pos", 32'(gnt_pos), (md == 0) ? 32'd3 : 32'd0);
        end

        // Single requester: saturated hold, never preempted.
        do_reset();
        mode = 1'($urandom_range(0, 1)); req = 4'b0100;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gnt == 4'b0100 && !preempt) cnt++;
        end
        check("single_hold", cnt, 20);

        // Reset in the middle of a grant clears everything including last.
        do_reset();
        req = 4'b0010;
        tick();
        check("pre_rst_gnt", 32'(gnt), 32'h2);
        rst = 1'b1;
        tick();
        check("rst_mid_gnt", 32'(gnt), 32'h0);
        check("rst_mid_pos", 32'(gnt_pos), 32'd0);
        check("rst_mid_valid", 32'(gnt_valid), 32'd0);
        check("rst_mid_pre", 32'(preempt), 32'd0);
        rst = 1'b0; req = 4'b0011; mode = 1'b1;
        tick();
        check("post_rst_rr", 32'(gnt_pos), 32'd1);

        // Release coincides with hold expiry: release wins, no preempt.
        do_reset();
        mode = 1'b0; req = 4'b1001;
        repeat (MAX_HOLD) tick();
        check("expiry_edge_gnt", 32'(gnt), 32'h8);
        req = 4'b0001;
        tick();
        check("rel_vs_pre_pre", 32'(preempt), 32'd0);
        check("rel_vs_pre_gnt", 32'(gnt), 32'h0);
        tick();
        check("rel_vs_pre_next", 32'(gnt), 32'h1);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) req = N'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
